// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions for the vector issue path: opcodes, instruction
// field layout and the issue controller state encoding.
package gpu_isa_pkg;

  localparam logic [3:0] OP_VADD = 4'h0;
  localparam logic [3:0] OP_VSUB = 4'h1;
  localparam logic [3:0] OP_VMUL = 4'h2;
  localparam logic [3:0] OP_VFMA = 4'h3;
  localparam logic [3:0] OP_RELU = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_LSB = 28;
  localparam int DT_LSB  = 24;
  localparam int RD_LSB  = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 12;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  dtype;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [11:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_DRAIN,
    S_HALTED
  } state_t;

endpackage

// File: rtl/control_unit.sv
// Instruction decoder: register fields plus write/halt/illegal classification.
module control_unit
  import gpu_isa_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  rd,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic        reg_write,
  output logic        is_halt,
  output logic        is_illegal
);

  instr_t f;
  logic   unused_fields;

  assign f          = instr;
  assign rd         = f.rd;
  assign rs1        = f.rs1;
  assign rs2        = f.rs2;
  assign reg_write  = (f.opcode <= OP_LD);
  assign is_halt    = (f.opcode == OP_HALT);
  assign is_illegal = !((f.opcode <= OP_ST) || is_halt);
  // dtype and imm travel with the instruction word but do not affect issue
  assign unused_fields = ^{f.dtype, f.imm};

endmodule

// File: rtl/issue_controller.sv
// Single-issue in-order controller: fetch, decode, scoreboard hazard check,
// valid/ready issue to execute, and drain-to-halt.
module issue_controller
  import gpu_isa_pkg::*;
#(
  parameter int PC_W = 9,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [31:0]     issue_instr,
  output logic [PC_W-1:0] issue_pc,
  input  logic            wb_valid,
  input  logic [3:0]      wb_rd,
  output logic            busy,
  output logic            halted,
  output logic            err_illegal
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [NREG-1:0] pending, wb_clr, iss_set, src_mask;
  logic [31:0]     dec_in;
  logic [3:0]      rd, rs1, rs2;
  logic            reg_write, is_halt, is_illegal;
  logic            hazard, fire;

  function automatic logic [NREG-1:0] reg_mask(logic [3:0] r);
    reg_mask = '0;
    for (int i = 0; i < NREG; i++)
      if (r == i[3:0]) reg_mask[i] = 1'b1;
  endfunction

  // One decoder serves both the fresh word in DECODE and the held word in ISSUE
  assign dec_in = (state == S_DECODE) ? imem_rdata : issue_instr;

  control_unit u_cu (
    .instr      (dec_in),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .reg_write  (reg_write),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // rd is always checked: WAW for writers, and a data source for ST
  assign src_mask    = reg_mask(rs1) | reg_mask(rs2) | reg_mask(rd);
  assign hazard      = |(pending & src_mask);
  assign issue_valid = (state == S_ISSUE) && !hazard;
  assign fire        = issue_valid && issue_ready;
  assign iss_set     = (fire && reg_write) ? reg_mask(rd) : '0;
  assign wb_clr      = wb_valid ? reg_mask(wb_rd) : '0;

  assign imem_addr = pc;
  assign busy      = (state != S_IDLE) && (state != S_HALTED);
  assign halted    = (state == S_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else if (state == S_IDLE && start)
      pending <= '0;
    else
      pending <= (pending & ~wb_clr) | iss_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      issue_instr <= '0;
      issue_pc    <= '0;
      err_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pc          <= start_pc;
          err_illegal <= 1'b0;
          state       <= S_FETCH;
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          issue_instr <= imem_rdata;
          issue_pc    <= pc;
          if (is_halt)
            state <= S_DRAIN;
          else if (is_illegal) begin
            err_illegal <= 1'b1;
            pc          <= pc + 1'b1;
            state       <= S_FETCH;
          end else
            state <= S_ISSUE;
        end
        S_ISSUE: if (fire) begin
          pc    <= pc + 1'b1;
          state <= S_FETCH;
        end
        S_DRAIN:  if (pending == '0) state <= S_HALTED;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/issue_controller.md
ISSUE_CONTROLLER -- requirements
Module: issue_controller

Interface
REQ-001 Parameter PC_W, default 9, SHALL set the instruction-memory word-address width.
REQ-002 Parameter NREG, default 16, SHALL set the number of scoreboard entries; the 4-bit register fields limit it to 16.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset; it is asynchronous and active-low.
REQ-005 start  input  1  SHALL be a one-cycle pulse that launches a kernel; it is honoured only in IDLE.
REQ-006 start_pc  input  PC_W  SHALL give the first instruction address, sampled with start.
REQ-007 imem_addr  output  PC_W  SHALL be the instruction-memory read address; the memory is synchronous with 1-cycle read latency.
REQ-008 imem_rdata  input  32  SHALL be the instruction word, valid the cycle after imem_addr is presented.
REQ-009 issue_valid  output  1  SHALL mean issue_instr/issue_pc hold a hazard-free instruction.
REQ-010 issue_ready  input  1  SHALL mean execute accepts the instruction this cycle.
REQ-011 issue_instr  output  32  SHALL carry the instruction word.
REQ-012 issue_pc  output  PC_W  SHALL carry the address of issue_instr.
REQ-013 wb_valid  input  1 and wb_rd  input  4 SHALL together retire one register write, clearing the pending bit for wb_rd.
REQ-014 busy  output  1  SHALL be high in every state except IDLE and HALTED.
REQ-015 halted  output  1  SHALL be high in HALTED.
REQ-016 err_illegal  output  1  SHALL be a sticky flag set when an illegal opcode is skipped.

Function
REQ-017 Instruction encoding SHALL be [31:28] opcode, [27:24] dtype, [23:20] rd, [19:16] rs1, [15:12] rs2, [11:0] imm.
REQ-018 Opcodes SHALL be: VADD 0, VSUB 1, VMUL 2, VFMA 3, RELU 4, LD 5, ST 6, HALT F; 7-E are illegal.
REQ-019 FSM states SHALL be IDLE, FETCH, DECODE, ISSUE, DRAIN and HALTED.
REQ-020 IDLE SHALL go to FETCH on start, loading pc=start_pc and clearing the scoreboard and err_illegal.
REQ-021 FETCH SHALL drive imem_addr=pc and go to DECODE.
REQ-022 DECODE SHALL register imem_rdata and route on opcode: HALT to DRAIN; illegal sets err_illegal, pc=pc+1, back to FETCH; otherwise to ISSUE.
REQ-023 Hazard SHALL be the pending bit of rs1, rs2 or rd being set in the registered scoreboard; the check SHALL cover RAW and WAW and treat ST's rd as a source.
REQ-024 In ISSUE, issue_valid SHALL equal !hazard; issue_valid SHALL NOT depend on issue_ready.
REQ-025 Once asserted, issue_valid, issue_instr and issue_pc SHALL hold until issue_valid&issue_ready.
REQ-026 On issue_valid&issue_ready, the controller SHALL set pending[rd] if the opcode is 0-5, set pc=pc+1 and go to FETCH.
REQ-027 pc SHALL wrap from 2^PC_W-1 to 0.
REQ-028 wb_valid SHALL clear pending[wb_rd] at the next edge.
REQ-029 A hazard check in the cycle a writeback arrives SHALL use the pre-clear mask, so issue can go ahead the following cycle.
REQ-030 If a set and a clear of the same bit occur in one cycle, the set SHALL win.
REQ-031 DRAIN SHALL wait until the scoreboard is all-zero, then go to HALTED.
REQ-032 HALTED SHALL be left only by reset; start is ignored there.
REQ-033 start while busy SHALL be ignored.
REQ-034 A wb_valid for a non-pending register SHALL have no effect.
REQ-035 Throughput SHALL be 1 instruction per 3 cycles when there is no hazard and issue_ready is high.

Reset
REQ-036 During reset, state SHALL be IDLE; pc, imem_addr, issue_pc and issue_instr SHALL be 0; issue_valid, busy, halted and err_illegal SHALL be 0; the scoreboard SHALL be cleared.
REQ-037 Reset mid-kernel SHALL abandon any held instruction immediately and drop issue_valid asynchronously.

Structure
REQ-038 The opcode localparams, field bit positions and the FSM state enum SHALL live in a shared package, gpu_isa_pkg.
REQ-039 The design SHALL instantiate the existing control_unit decoder as its one sub-module for field and reg_write extraction.

Verification
REQ-040 start_pc=0x010 with VADD r1,r2,r3 and issue_ready=1 -> imem_addr=0x010 at cycle 1, issue_valid at cycle 3 with issue_pc=0x010, FETCH 0x011 at cycle 4.
REQ-041 LD r4 followed by VADD r5,r4,r0 -> second issue_valid stays low until one cycle after wb_valid with wb_rd=4.
REQ-042 issue_ready low for 5 cycles -> issue_instr and issue_pc stable, exactly one handshake.
REQ-043 Opcode 0x8 at pc 7 -> err_illegal=1, never issued, next fetch at pc 8.
REQ-044 HALT with r2 pending -> DRAIN until wb_rd=2, then halted=1, busy=0; a later start is ignored.
REQ-045 start_pc=0x1FF -> next fetch at 0x000; rst_n low while issue_valid=1 -> all outputs 0 at once.
